rx_frame_stat_gen: RTL and testbench
====================================

RX_FRAME_STAT_GEN -- requirements
Module: rx_frame_stat_gen

Interface
REQ-001 Parameter MAX_LEN, default 1518, largest legal frame length in bytes; longer frames are oversize.
REQ-002 Parameter MIN_LEN, default 64, smallest legal frame length in bytes; shorter frames are runt.
REQ-003 Parameter VEC_NUM, default 4, number of vector entries driven; each entry is 36 bits.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clr_in  input  1  synchronous abort; discards the frame in progress.
REQ-007 rx_dv  input  1  byte valid; all other rx_* inputs are ignored when low.
REQ-008 rx_sof  input  1  first byte of frame; qualified by rx_dv.
REQ-009 rx_eof  input  1  last byte of frame; qualified by rx_dv.
REQ-010 rx_data  input  8  frame byte, DA first.
REQ-011 rx_err  input  1  PHY error on this byte; sticky for the frame.
REQ-012 rx_crc_ok  input  1  FCS result; sampled only on the eof byte.
REQ-013 stat_chk  output  1  one-cycle strobe; stat_bit and stat_vec are valid.
REQ-014 stat_bit  output  64  per-frame event flags.
REQ-015 stat_vec  output  36*VEC_NUM  entry k is bits [36k+35:36k] = {index[3:0], value[31:0]}; index 0 = no update.

Function
REQ-016 FSM states: IDLE, DA (bytes 1-6), BODY. Transitions: IDLE->DA on sof; DA->BODY after the 6th byte; DA/BODY->IDLE on eof, on clr_in, or on sof (restart).
REQ-017 Byte counter: 16-bit, counts rx_dv bytes from sof to eof inclusive, saturates at 0xFFFF; rx_dv gaps inside a frame are neither counted nor an error.
REQ-018 DA tracking: bcast flag set if all 6 DA bytes equal 0xFF; mcast flag set if bit0 of DA byte 1 is 1 and bcast is clear; ucast flag set otherwise. A frame ending before 6 DA bytes is classified ucast and runt.
REQ-019 Outputs are registered at the end of a frame; stat_chk is high exactly one cycle, in the cycle after the eof byte.
REQ-020 stat_bit map: [0] frame; [1] good = crc_ok & !err & MIN_LEN<=len<=MAX_LEN; [2] crc error; [3] rx_err; [4] runt; [5] oversize; [6] bcast; [7] mcast; [8] ucast; [9] len==64; [10] 65-127; [11] 128-255; [12] 256-511; [13] 512-1023; [14] 1024-MAX_LEN; [15] truncated; [63:16] 0.
REQ-021 stat_vec: entry0 = {1, len}; entry1 = good ? {2, len} : {0, 0}; entry2 = bit2 ? {3, len} : {0, 0}; entry3 = {4, 1} if bcast or mcast, else {0, 0}; entries >=4 = 0. len is zero-extended to 32 bits.
REQ-022 stat_bit and stat_vec hold their values between strobes.
REQ-023 sof while in DA/BODY: close the old frame with bit15=1 and bit1=0, without sampling crc. Its stat_chk occurs in the next cycle; the new frame starts counting from this sof byte.
REQ-024 sof and eof on the same byte: one-byte frame, len=1, runt, ucast, stat_chk in the next cycle.
REQ-025 eof or a non-sof byte in IDLE is ignored.
REQ-026 clr_in: FSM goes to IDLE; no stat_chk for the aborted frame. A strobe already pending in that cycle is suppressed. clr_in has priority over a simultaneous sof or eof.

Reset
REQ-027 On rst: FSM=IDLE, counter=0, flags=0, stat_chk=0, stat_bit=0, stat_vec=0. rst mid-frame discards the frame and produces no strobe after release.

Verification
REQ-028 64-byte frame, DA=FF:FF:FF:FF:FF:FF, crc_ok=1 -> one strobe, 1 cycle after eof; stat_bit=0x0000_0243; entry0={1,64}, entry1={2,64}, entry3={4,1}.
REQ-029 100-byte frame, DA byte1=0x01, crc_ok=0 -> stat_bit bits 0,2,7,10 set; entry1 index=0; entry2={3,100}.
REQ-030 sof+eof on a single byte -> len=1; bits 0,4,8 set.
REQ-031 sof at byte 30 of a frame -> strobe with bit15=1 and len=29; the next frame's length counts from the new sof.
REQ-032 clr_in at byte 10, and clr_in coincident with eof -> no strobe for that frame; the next frame reports normally.
REQ-033 2000-byte frame with rx_dv gaps -> len=2000, bit5=1, bit1=0; rst asserted mid-frame -> outputs 0 and no strobe.

Source files
------------

// File: rtl/rx_frame_stat_gen_if.sv
// Receive-side frame bus plus the per-frame statistics outputs.
// The master drives the byte stream; the slave (statistics block)
// returns the strobe, the event flags and the counter-update vector.
interface rx_frame_stat_gen_if #(
   parameter int VEC_NUM = 4
);
   logic                   rx_dv;
   logic                   rx_sof;
   logic                   rx_eof;
   logic [7:0]             rx_data;
   logic                   rx_err;
   logic                   rx_crc_ok;
   logic                   stat_chk;
   logic [63:0]            stat_bit;
   logic [36*VEC_NUM-1:0]  stat_vec;

   modport master (
      output rx_dv, rx_sof, rx_eof, rx_data, rx_err, rx_crc_ok,
      input  stat_chk, stat_bit, stat_vec
   );

   modport slave (
      input  rx_dv, rx_sof, rx_eof, rx_data, rx_err, rx_crc_ok,
      output stat_chk, stat_bit, stat_vec
   );
endinterface

// File: rtl/rx_frame_stat_gen.sv
// Per-frame receive statistics generator.
// Tracks one frame at a time (length, destination-address class, sticky
// PHY error) and, one cycle after the frame closes, emits a strobe with
// a 64-bit event-flag word and a list of {index, value} counter updates.
module rx_frame_stat_gen #(
   parameter int MAX_LEN = 1518,
   parameter int MIN_LEN = 64,
   parameter int VEC_NUM = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_in,
   rx_frame_stat_gen_if.slave bus
);

   localparam int          VW    = 36 * VEC_NUM;
   localparam logic [31:0] MIN_L = 32'(MIN_LEN);
   localparam logic [31:0] MAX_L = 32'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, DA, BODY} state_t;

   state_t        state, state_nx;
   logic [15:0]   cnt;
   logic          all_ff;
   logic          da_mc;
   logic          err_stk;

   logic          start_p0, cont_p0, trunc_p0, vld_p0;
   logic [15:0]   b_cnt;
   logic          b_ff, b_mc, b_err;
   logic [15:0]   len_p0;
   logic [63:0]   bits_p0;

   logic          vld_p1;
   logic [63:0]   stat_bit_p1;
   logic [VW-1:0] stat_vec_p1;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [63:0] make_bits(input logic [15:0] len,
                                             input logic ff, mc, err,
                                             input logic crc_bad, trunc);
      logic [31:0] l;
      logic        bc, mcst;
      logic [63:0] b;
      l    = {16'd0, len};
      b    = '0;
      // Fewer than six address bytes seen means the frame is unicast.
      bc   = (l >= 32'd6) & ff;
      mcst = (l >= 32'd6) & ~ff & mc;
      b[0]  = 1'b1;
      b[1]  = ~trunc & ~crc_bad & ~err & (l >= MIN_L) & (l <= MAX_L);
      b[2]  = crc_bad;
      b[3]  = err;
      b[4]  = (l < MIN_L);
      b[5]  = (l > MAX_L);
      b[6]  = bc;
      b[7]  = mcst;
      b[8]  = ~bc & ~mcst;
      b[9]  = (l == 32'd64);
      b[10] = (l >= 32'd65)   & (l <= 32'd127);
      b[11] = (l >= 32'd128)  & (l <= 32'd255);
      b[12] = (l >= 32'd256)  & (l <= 32'd511);
      b[13] = (l >= 32'd512)  & (l <= 32'd1023);
      b[14] = (l >= 32'd1024) & (l <= MAX_L);
      b[15] = trunc;
      return b;
   endfunction

   function automatic logic [VW-1:0] make_vec(input logic [63:0] b,
                                              input logic [15:0] len);
      logic [255:0]  all4;
      logic [35:0]   e0, e1, e2, e3;
      logic [VW-1:0] v;
      e0   = {4'd1, 16'd0, len};
      e1   = b[1] ? {4'd2, 16'd0, len} : 36'd0;
      e2   = b[2] ? {4'd3, 16'd0, len} : 36'd0;
      e3   = (b[6] | b[7]) ? {4'd4, 32'd1} : 36'd0;
      all4 = {112'd0, e3, e2, e1, e0};
      v    = '0;
      for (int i = 0; i < VW; i++) begin
         v[i] = (i < 144) ? all4[i[7:0]] : 1'b0;
      end
      return v;
   endfunction

   // Classify the current byte and form the closing-frame summary.
   always_comb begin
      start_p0 = bus.rx_dv & bus.rx_sof & ~clr_in;
      cont_p0  = bus.rx_dv & ~bus.rx_sof & ~clr_in & (state != IDLE);
      trunc_p0 = start_p0 & (state != IDLE);
      b_cnt    = cnt;
      b_ff     = all_ff;
      b_mc     = da_mc;
      b_err    = err_stk;
      if (start_p0) begin
         b_cnt = 16'd1;
         b_ff  = (bus.rx_data == 8'hFF);
         b_mc  = bus.rx_data[0];
         b_err = bus.rx_err;
      end else if (cont_p0) begin
         b_cnt = sat_inc(cnt);
         b_ff  = (cnt < 16'd6) ? (all_ff & (bus.rx_data == 8'hFF)) : all_ff;
         b_err = err_stk | bus.rx_err;
      end
      vld_p0 = trunc_p0 | (bus.rx_eof & ((start_p0 & (state == IDLE)) | cont_p0));
      // A restart closes the old frame as it stood before this byte.
      if (trunc_p0) begin
         len_p0  = cnt;
         bits_p0 = make_bits(cnt, all_ff, da_mc, err_stk, 1'b0, 1'b1);
      end else begin
         len_p0  = b_cnt;
         bits_p0 = make_bits(b_cnt, b_ff, b_mc, b_err, ~bus.rx_crc_ok, 1'b0);
      end
   end

   // Next-state logic; a restart that also carries eof leaves no open frame.
   always_comb begin
      state_nx = state;
      if (clr_in) begin
         state_nx = IDLE;
      end else if (start_p0) begin
         state_nx = bus.rx_eof ? IDLE : DA;
      end else if (cont_p0) begin
         if (bus.rx_eof)            state_nx = IDLE;
         else if (b_cnt >= 16'd6)   state_nx = BODY;
         else                       state_nx = DA;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Running frame length, address-class tracking and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         all_ff  <= 1'b0;
         da_mc   <= 1'b0;
         err_stk <= 1'b0;
      end else if (clr_in) begin
         cnt     <= '0;
         all_ff  <= 1'b0;
         da_mc   <= 1'b0;
         err_stk <= 1'b0;
      end else if (start_p0 | cont_p0) begin
         cnt     <= b_cnt;
         all_ff  <= b_ff;
         da_mc   <= b_mc;
         err_stk <= b_err;
      end
   end

   // ---- p0 -> p1: register the frame summary; outputs hold between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         stat_bit_p1 <= '0;
         stat_vec_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            stat_bit_p1 <= bits_p0;
            stat_vec_p1 <= make_vec(bits_p0, len_p0);
         end
      end
   end

   assign bus.stat_chk = vld_p1;
   assign bus.stat_bit = stat_bit_p1;
   assign bus.stat_vec = stat_vec_p1;

endmodule

// File: tb/tb_rx_frame_stat_gen.sv
// Bench for rx_frame_stat_gen: directed table of frames with hand-derived
// flag words, hand-written restart/abort/reset sequences, then random
// frames checked against a frame-level reference model.
module tb_rx_frame_stat_gen;
   localparam int MAX_LEN = 1518;
   localparam int MIN_LEN = 64;
   localparam int VEC_NUM = 4;
   localparam int VW      = 36 * VEC_NUM;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr_in = 1'b0;
   int   cyc = 0;

   rx_frame_stat_gen_if #(.VEC_NUM(VEC_NUM)) bus ();

   rx_frame_stat_gen #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .VEC_NUM(VEC_NUM)) dut (
      .clk(clk), .rst(rst), .clr_in(clr_in), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; logic [63:0] b; logic [VW-1:0] v; } exp_t;
   typedef struct { int len; int dak; bit crc; int errp; int gap; logic [63:0] eb; } vec_t;

   exp_t expq[$];
   exp_t pend;
   exp_t me;
   bit   pend_valid = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   function automatic logic [47:0] da_of(input int k);
      logic [63:0] r;
      case (k)
         0: return {8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h02};
         1: return 48'hFFFF_FFFF_FFFF;
         2: return {8'h01, 8'h00, 8'h00, 8'h5E, 8'h00, 8'h01};
         3: return {8'hFE, 40'hFF_FFFF_FFFF};
         4: return {40'hFF_FFFF_FFFF, 8'hFE};
         default: begin
            r = {$urandom, $urandom};
            return r[47:0];
         end
      endcase
   endfunction

   // Reference: flag word from the whole-frame description.
   function automatic logic [63:0] model_bits(input int len, input logic [47:0] da,
                                              input bit err, input bit crc, input bit trunc);
      logic [63:0] b;
      bit bc, mc;
      b     = '0;
      bc    = (len >= 6) && (da == 48'hFFFF_FFFF_FFFF);
      mc    = (len >= 6) && !bc && da[0];
      b[0]  = 1'b1;
      b[1]  = !trunc && crc && !err && len >= MIN_LEN && len <= MAX_LEN;
      b[2]  = !trunc && !crc;
      b[3]  = err;
      b[4]  = len < MIN_LEN;
      b[5]  = len > MAX_LEN;
      b[6]  = bc;
      b[7]  = mc;
      b[8]  = !bc && !mc;
      b[9]  = len == 64;
      b[10] = len >= 65 && len <= 127;
      b[11] = len >= 128 && len <= 255;
      b[12] = len >= 256 && len <= 511;
      b[13] = len >= 512 && len <= 1023;
      b[14] = len >= 1024 && len <= MAX_LEN;
      b[15] = trunc;
      return b;
   endfunction

   function automatic logic [VW-1:0] mk_vec(input logic [63:0] b, input int len);
      logic [VW-1:0] v;
      logic [31:0]   l;
      l = (len > 65535) ? 32'd65535 : 32'(len);
      v = '0;
      v[35:0] = {4'd1, l};
      if (b[1]) v[71:36] = {4'd2, l};
      if (b[2]) v[107:72] = {4'd3, l};
      if (b[6] | b[7]) v[143:108] = {4'd4, 32'd1};
      return v;
   endfunction

   task automatic chk_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic drive(input logic dv, sof, eof, input logic [7:0] d,
                        input logic err, crc, clr);
      @(negedge clk);
      bus.rx_dv = dv; bus.rx_sof = sof; bus.rx_eof = eof; bus.rx_data = d;
      bus.rx_err = err; bus.rx_crc_ok = crc; clr_in = clr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
   endtask

   // term: 0 = ends with eof, 1 = left open (closed by the next sof),
   //       2 = aborted by clr_in on byte clrp.
   task automatic send_frame(input int len, input int dak, input bit crc, input int errp,
                             input int gap, input int term, input int clrp,
                             input bit use_eb, input logic [63:0] eb);
      logic [47:0] da;
      logic [7:0]  d;
      logic [63:0] b;
      bit any_err, e, c, eo;
      int due;
      da = da_of(dak);
      any_err = 0;
      due = 0;
      for (int i = 1; i <= len; i++) begin
         if (i > 1) while ($urandom_range(0, 99) < gap) idle(1);
         d  = (i <= 6) ? da[8*(i-1) +: 8] : 8'($urandom);
         e  = (i == errp);
         c  = (term == 2) && (i == clrp);
         eo = ((term == 0) || c) && (i == len);
         any_err |= e;
         drive(1'b1, i == 1, eo, d, e, eo ? crc : 1'($urandom), c);
         if (i == 1 && pend_valid) begin
            if (!c) begin
               pend.due = cyc + 1;
               expq.push_back(pend);
            end
            pend_valid = 0;
         end
         if (c) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            return;
         end
         due = cyc + 1;
      end
      b = use_eb ? eb : model_bits(len, da, any_err, crc, term == 1);
      if (term == 0) expq.push_back('{due, b, mk_vec(b, len)});
      else begin
         pend = '{0, b, mk_vec(b, len)};
         pend_valid = 1;
      end
   endtask

   // Strobe monitor: exactly one strobe at each due cycle, none elsewhere.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (expq.size() != 0 && expq[0].due == cyc) begin
            me = expq.pop_front();
            n_chk++;
            if (bus.stat_chk === 1'b1 && bus.stat_bit === me.b && bus.stat_vec === me.v)
               n_pass++;
            else
               $display("FAIL strobe@%0d: chk=%b bit=%h vec=%h want chk=1 bit=%h vec=%h",
                        cyc, bus.stat_chk, bus.stat_bit, bus.stat_vec, me.b, me.v);
         end else begin
            n_chk++;
            if (bus.stat_chk === 1'b0) n_pass++;
            else $display("FAIL no_strobe@%0d: chk=%b want 0", cyc, bus.stat_chk);
         end
      end
   end

   vec_t tab[16];

   initial begin
      int len, dak, errp, gap, term, clrp, r;
      bit crc;
      tab[0]  = '{64,   1, 1, -1,  0, 64'h0243};
      tab[1]  = '{100,  2, 0, -1,  0, 64'h0485};
      tab[2]  = '{1,    0, 1, -1,  0, 64'h0111};
      tab[3]  = '{65,   0, 1, -1, 20, 64'h0503};
      tab[4]  = '{1518, 0, 1, -1,  0, 64'h4103};
      tab[5]  = '{1519, 0, 1, -1,  0, 64'h0121};
      tab[6]  = '{63,   1, 1, -1,  0, 64'h0051};
      tab[7]  = '{300,  2, 1, 150, 0, 64'h1089};
      tab[8]  = '{5,    1, 1, -1,  0, 64'h0111};
      tab[9]  = '{6,    1, 1, -1,  0, 64'h0051};
      tab[10] = '{200,  3, 1, -1,  0, 64'h0883};
      tab[11] = '{600,  4, 1, -1,  0, 64'h2103};
      tab[12] = '{1024, 0, 0, -1,  0, 64'h4105};
      tab[13] = '{127,  0, 1, 127, 0, 64'h0509};
      tab[14] = '{128,  0, 1, -1,  0, 64'h0903};
      tab[15] = '{2000, 0, 1, -1, 30, 64'h0121};

      bus.rx_dv = 0; bus.rx_sof = 0; bus.rx_eof = 0; bus.rx_data = 0;
      bus.rx_err = 0; bus.rx_crc_ok = 0;
      idle(3);
      chk_bits("reset_chk", {63'd0, bus.stat_chk}, 64'd0);
      chk_bits("reset_bit", bus.stat_bit, 64'd0);
      chk_vec("reset_vec", bus.stat_vec, '0);
      @(negedge clk) rst = 1'b0;
      idle(2);

      for (int t = 0; t < 16; t++) begin
         send_frame(tab[t].len, tab[t].dak, tab[t].crc, tab[t].errp, tab[t].gap, 0, 0, 1, tab[t].eb);
         idle(3);
         chk_bits($sformatf("hold_bit[%0d]", t), bus.stat_bit, tab[t].eb);
         chk_vec($sformatf("hold_vec[%0d]", t), bus.stat_vec, mk_vec(tab[t].eb, tab[t].len));
      end

      // Restart at byte 30: old frame closes truncated at 29 bytes.
      send_frame(29, 0, 0, -1, 0, 1, 0, 1, 64'h8111);
      send_frame(64, 1, 1, -1, 0, 0, 0, 1, 64'h0243);
      idle(3);

      // Stray bytes in IDLE are ignored; outputs keep the last frame.
      drive(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_bits("idle_stray_bit", bus.stat_bit, 64'h0243);

      // Abort at byte 10, then abort coincident with eof.
      send_frame(50, 0, 1, -1, 0, 2, 10, 1, 64'd0);
      idle(2);
      send_frame(70, 1, 1, -1, 0, 2, 70, 1, 64'd0);
      idle(2);
      chk_bits("clr_hold_bit", bus.stat_bit, 64'h0243);
      send_frame(65, 0, 1, -1, 0, 0, 0, 1, 64'h0503);
      idle(3);

      // Reset mid-frame: outputs clear and the open frame never reports.
      send_frame(40, 0, 1, -1, 0, 1, 0, 1, 64'd0);
      @(negedge clk) rst = 1'b1;
      pend_valid = 0;
      idle(1);
      chk_bits("midrst_chk", {63'd0, bus.stat_chk}, 64'd0);
      chk_bits("midrst_bit", bus.stat_bit, 64'd0);
      chk_vec("midrst_vec", bus.stat_vec, '0);
      @(negedge clk) rst = 1'b0;
      idle(5);
      send_frame(64, 1, 1, -1, 0, 0, 0, 1, 64'h0243);
      idle(3);

      // Random frames against the frame-level model.
      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      len = $urandom_range(1, 140);
         else if (r < 8) len = $urandom_range(140, 600);
         else            len = $urandom_range(1400, 1600);
         if (pend_valid && len == 1) len = 2;
         dak  = $urandom_range(0, 5);
         crc  = ($urandom_range(0, 3) != 0);
         errp = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : -1;
         gap  = ($urandom_range(0, 2) == 0) ? 25 : 0;
         r    = $urandom_range(0, 9);
         term = (r < 7) ? 0 : (r < 9) ? 1 : 2;
         if (n == 79) term = 0;
         clrp = $urandom_range(1, len);
         send_frame(len, dak, crc, errp, gap, term, clrp, 0, 64'd0);
         idle($urandom_range(0, 3));
         if (term != 1 && $urandom_range(0, 4) == 0)
            drive(1'b1, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      end
      idle(5);

      n_chk++;
      if (expq.size() == 0 && !pend_valid) n_pass++;
      else $display("FAIL drain: pending=%0d open=%0d want 0", expq.size(), pend_valid);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
